// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC scan controller and its tick generator.
package adc_pkg;

  localparam int ADC_DW = 12;
  localparam int CH_W   = 3;

  // ADC handshake polarities: start/oe are active-high, EOC is low while converting
  localparam logic START_ACT = 1'b1;
  localparam logic OE_ACT    = 1'b1;
  localparam logic EOC_BUSY  = 1'b0;
  localparam logic EOC_DONE  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    READ,
    OUTPUT
  } state_e;

  function automatic logic [CH_W-1:0] ch_next(input logic [CH_W-1:0] ch, input int nch);
    return (ch == CH_W'(nch - 1)) ? '0 : ch + 1'b1;
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Enable-gated clock divider: one-cycle tick every DIV cycles while enabled.
module adc_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == CW'(DIV - 1));

  // Disabling parks the counter at zero so the next enable starts a full period
  always_comb begin
    if (!enable_i || tick_o) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin ADC scan sequencer: start/EOC/OE handshake, sample hand-off,
// and sticky timeout/overrun flags for sensor-loss detection.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int SAMPLE_DIV = 1000,
  parameter int NCH        = 4,
  parameter int START_W    = 2,
  parameter int OE_W       = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  output logic              adc_start,
  input  logic              adc_eoc,
  output logic              adc_oe,
  input  logic [ADC_DW-1:0] adc_data,
  output logic [CH_W-1:0]   adc_ch_sel,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [ADC_DW-1:0] smp_data,
  output logic [CH_W-1:0]   smp_ch,
  output logic              err_timeout,
  output logic              err_overrun,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT + START_W + OE_W + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_ptr_q, ch_ptr_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic [ADC_DW-1:0] data_q, data_d;
  logic [CH_W-1:0]   smp_ch_q, smp_ch_d;
  logic              err_to_q, err_to_d;
  logic              err_ov_q, err_ov_d;
  logic              tick;
  logic              timeout_evt;

  adc_tick_gen #(
    .DIV(SAMPLE_DIV)
  ) u_tick (
    .clk     (clk),
    .rstn    (rstn),
    .enable_i(enable),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ch_ptr_q <= '0;
      ch_sel_q <= '0;
      data_q   <= '0;
      smp_ch_q <= '0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_ptr_q <= ch_ptr_d;
      ch_sel_q <= ch_sel_d;
      data_q   <= data_d;
      smp_ch_q <= smp_ch_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
    end
  end

  // cnt_q is shared: start width, EOC timeout (spanning both wait states), then OE width
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_ptr_d    = ch_ptr_q;
    ch_sel_d    = ch_sel_q;
    data_d      = data_q;
    smp_ch_d    = smp_ch_q;
    timeout_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          ch_sel_d = ch_ptr_q;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == CNT_W'(START_W - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_BUSY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_BUSY, WAIT_DONE: begin
        if (state_q == WAIT_DONE && adc_eoc == EOC_DONE) begin
          cnt_d   = '0;
          state_d = READ;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          ch_ptr_d    = ch_next(ch_ptr_q, NCH);
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == WAIT_BUSY && adc_eoc == EOC_BUSY) state_d = WAIT_DONE;
        end
      end
      READ: begin
        if (cnt_q == CNT_W'(OE_W - 1)) begin
          data_d   = adc_data;
          smp_ch_d = ch_sel_q;
          cnt_d    = '0;
          state_d  = OUTPUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (smp_ready) begin
          ch_ptr_d = ch_next(ch_ptr_q, NCH);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new error wins over a simultaneous clear
    err_to_d = (err_to_q && !err_clr) || timeout_evt;
    err_ov_d = (err_ov_q && !err_clr) || (tick && state_q != IDLE);
  end

  always_comb begin
    adc_start = (state_q == START) ? START_ACT : ~START_ACT;
    adc_oe    = (state_q == READ)  ? OE_ACT    : ~OE_ACT;
    smp_valid = (state_q == OUTPUT);
  end

  assign adc_ch_sel  = ch_sel_q;
  assign smp_data    = data_q;
  assign smp_ch      = smp_ch_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with an ADC model and a per-cycle reference model.
module tb_adc_scan_ctrl;

  localparam int SAMPLE_DIV = 32;
  localparam int NCH        = 4;
  localparam int START_W    = 2;
  localparam int OE_W       = 2;
  localparam int TIMEOUT    = 64;
  localparam int CONV       = 10;

  localparam int S_START_HI = 0, S_START_LO = 1, S_OE_HI = 2, S_VALID = 3,
                 S_ETO = 4, S_EOC_LO = 5, S_EOC_HI = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        adc_start, adc_eoc, adc_oe;
  logic [11:0] adc_data = 12'hA5C;
  logic [2:0]  adc_ch_sel;
  logic        smp_valid, smp_ready = 1'b1;
  logic [11:0] smp_data;
  logic [2:0]  smp_ch;
  logic        err_timeout, err_overrun, err_clr = 1'b0;
  logic        adc_hang = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  adc_scan_ctrl #(
    .SAMPLE_DIV(SAMPLE_DIV), .NCH(NCH), .START_W(START_W), .OE_W(OE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .adc_start(adc_start), .adc_eoc(adc_eoc), .adc_oe(adc_oe), .adc_data(adc_data),
    .adc_ch_sel(adc_ch_sel), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_data(smp_data), .smp_ch(smp_ch),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ADC: EOC drops while start is seen and stays low CONV cycles after start ends
  int busy = 0;
  initial begin
    adc_eoc = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (adc_start) busy = CONV;
      else if (busy > 0) busy--;
      adc_eoc = adc_hang ? 1'b1 : (busy == 0);
    end
  end

  // Reference model: scan timeline described by remaining-cycle counters
  int          m_tcnt, m_start_rem, m_wait, m_oe_rem, m_ch_ptr;
  bit          m_scan, m_seen_busy, m_valid, m_eto, m_eov;
  logic [11:0] m_data;
  logic [2:0]  m_sel, m_smp_ch;

  task automatic m_reset();
    m_tcnt = 0; m_start_rem = 0; m_wait = -1; m_oe_rem = 0; m_ch_ptr = 0;
    m_scan = 0; m_seen_busy = 0; m_valid = 0; m_eto = 0; m_eov = 0;
    m_data = '0; m_sel = '0; m_smp_ch = '0;
  endtask

  task automatic m_step();
    bit tick, new_to, new_ov;
    tick   = enable && (m_tcnt == SAMPLE_DIV - 1);
    m_tcnt = (enable && !tick) ? m_tcnt + 1 : 0;
    new_to = 0;
    new_ov = tick && m_scan;
    if (!m_scan) begin
      if (tick) begin
        m_scan = 1; m_start_rem = START_W; m_sel = 3'(m_ch_ptr);
      end
    end else if (m_start_rem > 0) begin
      m_start_rem--;
      if (m_start_rem == 0) begin m_wait = 0; m_seen_busy = 0; end
    end else if (m_wait >= 0) begin
      if (m_seen_busy && adc_eoc) begin
        m_wait = -1; m_oe_rem = OE_W;
      end else if (m_wait == TIMEOUT - 1) begin
        m_wait = -1; m_scan = 0; new_to = 1; m_ch_ptr = (m_ch_ptr + 1) % NCH;
      end else begin
        if (!adc_eoc) m_seen_busy = 1;
        m_wait++;
      end
    end else if (m_oe_rem > 0) begin
      if (m_oe_rem == 1) begin m_data = adc_data; m_smp_ch = m_sel; m_valid = 1; end
      m_oe_rem--;
    end else if (m_valid && smp_ready) begin
      m_valid = 0; m_scan = 0; m_ch_ptr = (m_ch_ptr + 1) % NCH;
    end
    m_eto = (m_eto && !err_clr) || new_to;
    m_eov = (m_eov && !err_clr) || new_ov;
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rstn) m_reset();
      check("m_adc_start",   32'(adc_start),   32'(m_start_rem > 0));
      check("m_adc_oe",      32'(adc_oe),      32'(m_oe_rem > 0));
      check("m_smp_valid",   32'(smp_valid),   32'(m_valid));
      check("m_smp_data",    32'(smp_data),    32'(m_data));
      check("m_smp_ch",      32'(smp_ch),      32'(m_smp_ch));
      check("m_adc_ch_sel",  32'(adc_ch_sel),  32'(m_sel));
      check("m_err_timeout", 32'(err_timeout), 32'(m_eto));
      check("m_err_overrun", 32'(err_overrun), 32'(m_eov));
      if (rstn) m_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      S_START_HI: return adc_start;
      S_START_LO: return !adc_start;
      S_OE_HI:    return adc_oe;
      S_VALID:    return smp_valid;
      S_ETO:      return err_timeout;
      S_EOC_LO:   return !adc_eoc;
      default:    return adc_eoc;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int budget, output int n);
    n = 0;
    while (!sig(sel) && n < budget) begin cyc(); n++; end
    if (!sig(sel)) begin
      n_chk++; n_fail++;
      $display("FAIL wait_%0d: event not seen within %0d cycles", sel, budget);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) cyc();
    rstn = 1'b1;
  endtask

  initial begin
    int n, w, rises;
    logic [11:0] d0;
    logic [2:0]  c0;
    bit stable;
    enable = 1'b1;
    repeat (2) cyc();
    check("rst_adc_start", 32'(adc_start), 0);
    check("rst_smp_valid", 32'(smp_valid), 0);
    check("rst_err", 32'({err_timeout, err_overrun}), 0);
    rstn = 1'b1;

    // Nominal scan
    wait_sig(S_START_HI, 100, n);
    w = 0;
    while (adc_start && w < 10) begin cyc(); w++; end
    check("start_width", 32'(w), START_W);
    wait_sig(S_OE_HI, 50, n);
    w = 0;
    while (adc_oe && w < 10) begin cyc(); w++; end
    check("oe_width", 32'(w), OE_W);
    wait_sig(S_VALID, 10, n);
    check("nom_data", 32'(smp_data), 32'h0A5C);
    check("nom_ch", 32'(smp_ch), 0);
    for (int k = 1; k <= 4; k++) begin
      adc_data = 12'h111 * 12'(k);
      cyc();
      wait_sig(S_EOC_LO, 100, n);
      wait_sig(S_EOC_HI, 50, n);
      wait_sig(S_VALID, 10, n);
      check("eoc_to_valid", 32'(n), OE_W + 1);
      check("seq_ch", 32'(smp_ch), 32'(k % NCH));
      check("seq_data", 32'(smp_data), 32'h111 * k);
    end
    check("nom_no_overrun", 32'(err_overrun), 0);

    // Backpressure
    cyc();
    smp_ready = 1'b0;
    adc_data  = 12'h3C7;
    wait_sig(S_VALID, 100, n);
    d0 = smp_data; c0 = smp_ch; stable = 1;
    repeat (100) begin
      cyc();
      if (!smp_valid || smp_data != d0 || smp_ch != c0) stable = 0;
    end
    check("bp_stable", 32'(stable), 1);
    check("bp_data", 32'(d0), 32'h3C7);
    check("bp_overrun", 32'(err_overrun), 1);
    smp_ready = 1'b1;
    cyc();
    check("bp_accepted", 32'(smp_valid), 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("ovr_clr", 32'(err_overrun), 0);

    // Timeout: EOC never drops
    adc_hang = 1'b1;
    do_reset();
    wait_sig(S_START_HI, 100, n);
    check("to_ch_sel0", 32'(adc_ch_sel), 0);
    wait_sig(S_START_LO, 10, n);
    wait_sig(S_ETO, 200, n);
    check("to_latency", 32'(n), TIMEOUT);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("to_clr", 32'(err_timeout), 0);
    wait_sig(S_START_HI, 100, n);
    check("to_next_ch", 32'(adc_ch_sel), 1);
    wait_sig(S_START_LO, 10, n);
    repeat (TIMEOUT - 1) cyc();
    check("to_not_yet", 32'(err_timeout), 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("to_clr_collide", 32'(err_timeout), 1);
    adc_hang = 1'b0;
    adc_data = 12'h5A5;
    wait_sig(S_VALID, 200, n);
    check("to_after_ch", 32'(smp_ch), 2);
    check("to_after_data", 32'(smp_data), 32'h5A5);

    // Reset during READ
    cyc();
    wait_sig(S_OE_HI, 100, n);
    rstn = 1'b0;
    #1;
    check("rst_oe_async", 32'(adc_oe), 0);
    check("rst_valid_async", 32'(smp_valid), 0);
    repeat (2) cyc();
    rstn = 1'b1;
    cyc();
    check("rst_no_stale", 32'(smp_valid), 0);
    adc_data = 12'h0F0;
    wait_sig(S_VALID, 100, n);
    check("rst_first_ch", 32'(smp_ch), 0);
    check("rst_first_data", 32'(smp_data), 32'h0F0);

    // enable drops mid-conversion
    cyc();
    adc_data = 12'h777;
    wait_sig(S_START_HI, 100, n);
    wait_sig(S_START_LO, 10, n);
    repeat (3) cyc();
    enable = 1'b0;
    wait_sig(S_VALID, 50, n);
    check("dis_ch", 32'(smp_ch), 1);
    check("dis_data", 32'(smp_data), 32'h777);
    rises = 0;
    repeat (3 * SAMPLE_DIV) begin
      cyc();
      if (adc_start) rises++;
    end
    check("dis_no_start", 32'(rises), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
